// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multicycle multiply/divide unit and the control FSM that drives it.
package mult_div_unit_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1a;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Signed multiply/divide, one bit per cycle on magnitudes with a final sign-fix cycle.
// Handshake: start is sampled only in IDLE; done/div_zero are one-cycle pulses, hi/lo valid from done.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH:0]   opnd_q, opnd_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]     a_ext, b_ext, abs_a, abs_b;
    logic [WIDTH:0]     shifted, add_lhs, add_rhs, sum;
    logic [2*WIDTH-1:0] prod;

    // Magnitudes are W+1 bits wide so the most negative operand survives negation.
    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = {b[WIDTH-1], b};
    assign abs_a = a[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
    assign abs_b = b[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;

    // One adder serves both ops: MULT adds the multiplicand, DIV subtracts the divisor.
    assign shifted = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    assign add_lhs = op_q ? shifted : acc_q;
    assign add_rhs = op_q ? ~opnd_q : (mq_q[0] ? opnd_q : '0);
    assign sum     = add_lhs + add_rhs + {{WIDTH{1'b0}}, op_q};
    assign prod    = {acc_q[WIDTH-1:0], mq_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_DIV && b == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        state_d  = S_ITER;
                        busy_d   = 1'b1;
                        op_d     = op;
                        cnt_d    = CW'(WIDTH - 1);
                        acc_d    = '0;
                        mq_d     = (op == OP_DIV) ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0];
                        opnd_d   = (op == OP_DIV) ? abs_b : abs_a;
                        neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_hi_d = a[WIDTH-1];
                    end
                end
            end
            S_ITER: begin
                if (op_q == OP_DIV) begin
                    // A set top bit means the trial subtraction borrowed: restore.
                    acc_d = sum[WIDTH] ? shifted : sum;
                    mq_d  = {mq_q[WIDTH-2:0], ~sum[WIDTH]};
                end else begin
                    acc_d = {1'b0, sum[WIDTH:1]};
                    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q == OP_DIV) begin
                    lo_d = neg_lo_q ? -mq_q : mq_q;
                    hi_d = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -prod : prod;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus randomized ops against a longint reference.
module tb_mult_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_checks++;
        if (done && div_zero) begin
            n_errors++;
            $display("FAIL done_and_div_zero at %0t: both high, required never together", $time);
        end
    end

    // Reference: plain signed 64-bit arithmetic; / truncates toward zero, % follows the dividend.
    function automatic logic [63:0] model(input bit o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r, p;
        sx = $signed(x);
        sy = $signed(y);
        if (!o) begin
            p = sx * sy;
            return p;
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Starts one op from the current cycle; returns at the done cycle (or after a bounded wait).
    task automatic run_op(input bit o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output int lat, output int busy_cnt, output bit dz_seen, output bit busy_at_done);
        int n;
        busy_cnt = 0;
        dz_seen = 0;
        lat = -1;
        busy_at_done = 0;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
        n = 1;
        while (n <= 100) begin
            if (div_zero) dz_seen = 1;
            if (done) begin
                lat = n;
                busy_at_done = busy;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            n++;
        end
        r_hi = hi;
        r_lo = lo;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, div_zero} !== 3'b000 || hi !== '0 || lo !== '0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h st=%0d, required all zero",
                     busy, done, div_zero, hi, lo, dbg_state);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        bit          ops [7]  = '{0, 0, 0, 1, 1, 1, 1};
        logic [31:0] xs  [7]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'd100, 32'h80000000};
        logic [31:0] ys  [7]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd7, 32'd7};
        logic [63:0] exps[7]  = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'h00000000_00000001,
                                  64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000002_0000000E,
                                  64'hFFFFFFFE_EDB6DB6E};
        logic [31:0] rh, rl;
        int lat, bc;
        bit dz, bd;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], xs[i], ys[i], rh, rl, lat, bc, dz, bd);
            n_checks++;
            if ({rh, rl} !== exps[i]) begin
                n_errors++;
                $display("FAIL directed_%0d result: hi=%h lo=%h, required hi=%h lo=%h",
                         i, rh, rl, exps[i][63:32], exps[i][31:0]);
            end
            n_checks++;
            if (lat !== LAT || bc !== LAT - 1 || bd !== 1'b0 || dz !== 1'b0) begin
                n_errors++;
                $display("FAIL directed_%0d timing: lat=%0d busy_cycles=%0d busy_at_done=%b dz=%b, required %0d %0d 0 0",
                         i, lat, bc, bd, dz, LAT, LAT - 1);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] rh, rl, px, py;
        logic [63:0] e;
        int lat, bc;
        bit dz, bd;
        px = $urandom; py = $urandom;
        e = model(0, px, py);
        run_op(0, px, py, rh, rl, lat, bc, dz, bd);
        n_checks++;
        if ({rh, rl} !== e) begin
            n_errors++;
            $display("FAIL dz_preload: hi=%h lo=%h, required hi=%h lo=%h", rh, rl, e[63:32], e[31:0]);
        end
        start = 1'b1; op = 1'b1; a = 32'd5; b = '0;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        n_checks++;
        if ({div_zero, busy, done} !== 3'b100 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL dz_pulse: dz=%b busy=%b done=%b st=%0d, required dz=1 busy=0 done=0 st=0",
                     div_zero, busy, done, dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({div_zero, busy, done} !== 3'b000) begin
                n_errors++;
                $display("FAIL dz_after_%0d: dz=%b busy=%b done=%b, required all 0", i, div_zero, busy, done);
            end
        end
        n_checks++;
        if ({hi, lo} !== e) begin
            n_errors++;
            $display("FAIL dz_hold: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rh, rl, mx, my;
        logic [63:0] e;
        int lat, bc;
        bit dz, bd;
        run_op(1, 32'h80000000, 32'hFFFFFFFF, rh, rl, lat, bc, dz, bd);
        n_checks++;
        if (rh !== 32'h0 || rl !== 32'h80000000 || dz !== 1'b0 || lat !== LAT) begin
            n_errors++;
            $display("FAIL b2b_div_min: hi=%h lo=%h dz=%b lat=%0d, required hi=0 lo=80000000 dz=0 lat=%0d",
                     rh, rl, dz, lat, LAT);
        end
        mx = $urandom; my = $urandom;
        e = model(0, mx, my);
        run_op(0, mx, my, rh, rl, lat, bc, dz, bd);
        n_checks++;
        if ({rh, rl} !== e || lat !== LAT) begin
            n_errors++;
            $display("FAIL b2b_mult: hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=%0d",
                     rh, rl, lat, e[63:32], e[31:0], LAT);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
        n = 1;
        repeat (4) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        n++;
        start = 1'b0;
        while (!done && n <= 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (hi !== 32'd2 || lo !== 32'd14 || n !== LAT) begin
            n_errors++;
            $display("FAIL ignore_start: hi=%h lo=%h lat=%0d, required hi=2 lo=e lat=%0d", hi, lo, n, LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rh, rl;
        int lat, bc;
        bit dz, bd, saw;
        start = 1'b1; op = 1'b0; a = $urandom | 32'h1; b = $urandom | 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b st=%0d, required all zero",
                     busy, hi, lo, done, dbg_state);
        end
        saw = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || div_zero) saw = 1;
        end
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || div_zero || busy) saw = 1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_quiet: activity seen=%b after abort, required 0", saw);
        end
        run_op(0, 32'd3, 32'd4, rh, rl, lat, bc, dz, bd);
        n_checks++;
        if (rh !== 32'd0 || rl !== 32'd12 || lat !== LAT) begin
            n_errors++;
            $display("FAIL reset_mid_recover: hi=%h lo=%h lat=%0d, required hi=0 lo=c lat=%0d", rh, rl, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        logic [31:0] x, y, rh, rl;
        logic [63:0] e;
        int lat, bc;
        bit o, dz, bd;
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom);
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(8, 30);
            if (o && y == '0) y = 32'd3;
            e = model(o, x, y);
            run_op(o, x, y, rh, rl, lat, bc, dz, bd);
            n_checks++;
            if ({rh, rl} !== e || lat !== LAT || dz !== 1'b0) begin
                n_errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d dz=%b, required hi=%h lo=%h lat=%0d dz=0",
                         i, o, x, y, rh, rl, lat, dz, e[63:32], e[31:0], LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
